// File: rtl/div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_request_sequencer
// Brief    : Request FIFO and handshake sequencer for the 8-bit signed
//            iterative divider, with local divide-by-zero/overflow handling.
// Revision : 1.0 - initial release
// ============================================================================
module div_request_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_dividend,
    input  logic [7:0]       req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_quotient,
    output logic [7:0]       res_remainder,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_dbz,
    output logic             res_ovf,
    output logic             div_start,
    output logic [7:0]       div_dividend,
    output logic [7:0]       div_divisor,
    input  logic             div_ready,
    input  logic [7:0]       div_quotient,
    input  logic [7:0]       div_remainder
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_OUTPUT    = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_guard;
    logic [TAG_W-1:0] r_cur_tag;

    logic [7:0]       r_fifo_dividend [DEPTH];
    logic [7:0]       r_fifo_divisor  [DEPTH];
    logic [TAG_W-1:0] r_fifo_tag      [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head_dividend;
    logic [7:0]       w_head_divisor;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_head_dbz;
    logic             w_head_ovf;
    logic [7:0]       w_rem_fix;

    assign w_empty         = (r_count == '0);
    assign w_full          = (r_count == CNT_W'(DEPTH));
    assign req_ready       = !w_full;
    assign w_push          = req_valid && !w_full;
    assign w_head_dividend = r_fifo_dividend[r_rd_ptr];
    assign w_head_divisor  = r_fifo_divisor[r_rd_ptr];
    assign w_head_tag      = r_fifo_tag[r_rd_ptr];
    assign w_head_dbz      = (w_head_divisor == 8'h00);
    assign w_head_ovf      = (w_head_dividend == 8'h80) && (w_head_divisor == 8'hFF);
    // Bypass cases never touch the divider, so they do not wait on div_ready.
    assign w_pop           = (r_state == S_IDLE) && !w_empty &&
                             (w_head_dbz || w_head_ovf || div_ready);
    assign w_rem_fix       = div_dividend[7] ? (8'd0 - div_remainder) : div_remainder;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_dividend[r_wr_ptr] <= req_dividend;
            r_fifo_divisor[r_wr_ptr]  <= req_divisor;
            r_fifo_tag[r_wr_ptr]      <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_guard       <= 1'b0;
            r_cur_tag     <= '0;
            res_valid     <= 1'b0;
            res_quotient  <= 8'h00;
            res_remainder <= 8'h00;
            res_tag       <= '0;
            res_dbz       <= 1'b0;
            res_ovf       <= 1'b0;
            div_start     <= 1'b0;
            div_dividend  <= 8'h00;
            div_divisor   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head_dbz) begin
                            res_quotient  <= 8'h00;
                            res_remainder <= w_head_dividend;
                            res_tag       <= w_head_tag;
                            res_dbz       <= 1'b1;
                            res_ovf       <= 1'b0;
                            res_valid     <= 1'b1;
                            r_state       <= S_OUTPUT;
                        end else if (w_head_ovf) begin
                            res_quotient  <= 8'h80;
                            res_remainder <= 8'h00;
                            res_tag       <= w_head_tag;
                            res_dbz       <= 1'b0;
                            res_ovf       <= 1'b1;
                            res_valid     <= 1'b1;
                            r_state       <= S_OUTPUT;
                        end else begin
                            div_dividend <= w_head_dividend;
                            div_divisor  <= w_head_divisor;
                            r_cur_tag    <= w_head_tag;
                            div_start    <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    div_start <= 1'b0;
                    r_guard   <= 1'b1;
                    r_state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // The divider's ready may still read high for a cycle after start.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (div_ready) begin
                        res_quotient  <= div_quotient;
                        res_remainder <= w_rem_fix;
                        res_tag       <= r_cur_tag;
                        res_dbz       <= 1'b0;
                        res_ovf       <= 1'b0;
                        res_valid     <= 1'b1;
                        r_state       <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
